// File: rtl/rammodel_fixed_latency_timing.sv
// Cycle-accounting timing model for the simple RAM model: decides when R beats and
// B responses become eligible, with latency counted in stall-free model cycles.
module rammodel_fixed_latency_timing #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned R_DELAY    = 25,
  parameter int unsigned W_DELAY    = 3,
  parameter int unsigned R_DEPTH    = 8,
  parameter int unsigned B_DEPTH    = 8,
  parameter int unsigned TIME_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  arvalid,
  output logic                  arready,
  input  logic [ADDR_WIDTH-1:0] araddr,
  input  logic [7:0]            arlen,
  input  logic [2:0]            arsize,
  input  logic [1:0]            arburst,
  output logic                  rvalid,
  input  logic                  rready,
  input  logic                  awvalid,
  output logic                  awready,
  input  logic [ADDR_WIDTH-1:0] awaddr,
  input  logic [7:0]            awlen,
  input  logic [2:0]            awsize,
  input  logic [1:0]            awburst,
  input  logic                  wvalid,
  output logic                  wready,
  input  logic                  wlast,
  output logic                  bvalid,
  input  logic                  bready,
  input  logic                  stall
);

  localparam int unsigned RAW = $clog2(R_DEPTH);
  localparam int unsigned BAW = $clog2(B_DEPTH);
  localparam int unsigned UW  = BAW + 1;
  localparam logic [RAW:0]            R_FULL = (RAW+1)'(R_DEPTH);
  localparam logic [BAW:0]            B_FULL = (BAW+1)'(B_DEPTH);
  localparam logic [UW-1:0]           U_MAX  = UW'(B_DEPTH);
  localparam logic [TIME_WIDTH-1:0]   R_DLY  = TIME_WIDTH'(R_DELAY);
  localparam logic [TIME_WIDTH-1:0]   W_DLY  = TIME_WIDTH'(W_DELAY);

  typedef enum logic {R_IDLE = 1'b0, R_BURST = 1'b1} r_state_e;

  // Wrap-safe: due once (t - due) is non-negative as a signed TIME_WIDTH value.
  function automatic logic is_due(input logic [TIME_WIDTH-1:0] t,
                                  input logic [TIME_WIDTH-1:0] due);
    logic [TIME_WIDTH-1:0] diff;
    diff = t - due;
    return ~diff[TIME_WIDTH-1];
  endfunction

  logic [TIME_WIDTH-1:0] now_q, now_next;

  logic [7:0]            rq_len_q [R_DEPTH];
  logic [TIME_WIDTH-1:0] rq_due_q [R_DEPTH];
  logic [RAW:0]          rq_wr_q, rq_rd_q, rq_count;
  logic [RAW-1:0]        rq_head, rq_next;
  logic                  rq_empty, rq_full, rq_push, rq_pop;
  r_state_e              r_state_q, r_state_d;
  logic [7:0]            beat_q, beat_d;

  logic [TIME_WIDTH-1:0] bq_due_q [B_DEPTH];
  logic [BAW:0]          bq_wr_q, bq_rd_q, bq_count;
  logic                  bq_empty, bq_full, bq_push, bq_pop;
  logic [UW-1:0]         unm_q, unm_d;
  logic                  aw_hs;

  logic unused_inputs;
  assign unused_inputs = ^{araddr, arsize, arburst, awaddr, awlen, awsize, awburst};

  assign now_next = now_q + TIME_WIDTH'(1);

  assign rq_count = rq_wr_q - rq_rd_q;
  assign rq_empty = (rq_count == '0);
  assign rq_full  = (rq_count == R_FULL);
  assign rq_head  = rq_rd_q[RAW-1:0];
  assign rq_next  = rq_head + RAW'(1);
  assign arready  = resetn && !stall && !rq_full;
  assign rq_push  = arvalid && arready;
  assign rvalid   = (r_state_q == R_BURST);

  assign bq_count = bq_wr_q - bq_rd_q;
  assign bq_empty = (bq_count == '0);
  assign bq_full  = (bq_count == B_FULL);
  assign awready  = resetn && !stall && (unm_q != U_MAX);
  assign wready   = resetn && !stall && (unm_q != '0) && !bq_full;
  assign aw_hs    = awvalid && awready;
  assign bq_push  = wvalid && wready && wlast;
  assign bvalid   = !bq_empty && is_due(now_q, bq_due_q[bq_rd_q[BAW-1:0]]);
  assign bq_pop   = bvalid && bready && !stall;

  // Burst entry looks one model cycle ahead so rvalid is high in the cycle now == due.
  always_comb begin
    r_state_d = r_state_q;
    beat_d    = beat_q;
    rq_pop    = 1'b0;
    case (r_state_q)
      R_IDLE: begin
        if (!stall && !rq_empty && is_due(now_next, rq_due_q[rq_head])) begin
          r_state_d = R_BURST;
          beat_d    = rq_len_q[rq_head];
        end
      end
      R_BURST: begin
        if (rready && !stall) begin
          if (beat_q != 8'd0) begin
            beat_d = beat_q - 8'd1;
          end else begin
            rq_pop = 1'b1;
            if (rq_count > (RAW+1)'(1) && is_due(now_next, rq_due_q[rq_next])) begin
              beat_d = rq_len_q[rq_next];
            end else begin
              r_state_d = R_IDLE;
            end
          end
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_comb begin
    unm_d = unm_q;
    case ({aw_hs, bq_push})
      2'b10:   unm_d = unm_q + UW'(1);
      2'b01:   unm_d = unm_q - UW'(1);
      default: unm_d = unm_q;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      now_q     <= '0;
      rq_wr_q   <= '0;
      rq_rd_q   <= '0;
      r_state_q <= R_IDLE;
      beat_q    <= '0;
      bq_wr_q   <= '0;
      bq_rd_q   <= '0;
      unm_q     <= '0;
    end else begin
      if (!stall) now_q <= now_next;
      if (rq_push) rq_wr_q <= rq_wr_q + (RAW+1)'(1);
      if (rq_pop)  rq_rd_q <= rq_rd_q + (RAW+1)'(1);
      r_state_q <= r_state_d;
      beat_q    <= beat_d;
      if (bq_push) bq_wr_q <= bq_wr_q + (BAW+1)'(1);
      if (bq_pop)  bq_rd_q <= bq_rd_q + (BAW+1)'(1);
      unm_q     <= unm_d;
    end
  end

  // Queue payload storage needs no reset: entries are only read when occupied.
  always_ff @(posedge clk) begin
    if (rq_push) begin
      rq_len_q[rq_wr_q[RAW-1:0]] <= arlen;
      rq_due_q[rq_wr_q[RAW-1:0]] <= now_q + R_DLY;
    end
    if (bq_push) bq_due_q[bq_wr_q[BAW-1:0]] <= now_q + W_DLY;
  end

endmodule

// File: tb/tb_rammodel_fixed_latency_timing.sv
// Directed bench for rammodel_fixed_latency_timing: a write-path vector table plus
// hand-written read, stall, queue-full, wrap and reset sequences.
module tb_rammodel_fixed_latency_timing;

  logic        clk = 1'b0;
  logic        resetn;
  logic        arvalid, rready, awvalid, wvalid, wlast, bready, stall;
  logic [31:0] araddr, awaddr;
  logic [7:0]  arlen, awlen;
  logic [2:0]  arsize, awsize;
  logic [1:0]  arburst, awburst;
  logic        arready, rvalid, awready, wready, bvalid;
  logic        arready_w, rvalid_w, awready_w, wready_w, bvalid_w;

  int          n_checks = 0;
  int          n_fail   = 0;
  int unsigned now_m    = 0;

  typedef struct {
    logic aw, w, wl, br, st;
    logic e_awr, e_wr, e_bv;
  } wrow_t;
  wrow_t wt [16];

  always #5 clk = ~clk;

  rammodel_fixed_latency_timing u_dut (
    .clk(clk), .resetn(resetn),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arlen(arlen),
    .arsize(arsize), .arburst(arburst), .rvalid(rvalid), .rready(rready),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awlen(awlen),
    .awsize(awsize), .awburst(awburst), .wvalid(wvalid), .wready(wready),
    .wlast(wlast), .bvalid(bvalid), .bready(bready), .stall(stall)
  );

  // Narrow model-time instance so the counter wraps within a short run.
  rammodel_fixed_latency_timing #(.TIME_WIDTH(6)) u_dut_w (
    .clk(clk), .resetn(resetn),
    .arvalid(arvalid), .arready(arready_w), .araddr(araddr), .arlen(arlen),
    .arsize(arsize), .arburst(arburst), .rvalid(rvalid_w), .rready(rready),
    .awvalid(awvalid), .awready(awready_w), .awaddr(awaddr), .awlen(awlen),
    .awsize(awsize), .awburst(awburst), .wvalid(wvalid), .wready(wready_w),
    .wlast(wlast), .bvalid(bvalid_w), .bready(bready), .stall(stall)
  );

  function automatic wrow_t mk(input logic [7:0] v);
    wrow_t r;
    r.aw = v[7]; r.w = v[6]; r.wl = v[5]; r.br = v[4]; r.st = v[3];
    r.e_awr = v[2]; r.e_wr = v[1]; r.e_bv = v[0];
    return r;
  endfunction

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic chkn(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc();
    if (resetn && !stall) now_m++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    arvalid = 1'b0; rready = 1'b0; awvalid = 1'b0; wvalid = 1'b0; wlast = 1'b0;
    bready = 1'b0; stall = 1'b0; araddr = '0; awaddr = '0; arlen = '0; awlen = '0;
    arsize = '0; awsize = '0; arburst = '0; awburst = '0;
  endtask

  task automatic do_reset();
    idle_in();
    resetn = 1'b0;
    now_m  = 0;
    cyc();
    cyc();
    resetn = 1'b1;
  endtask

  // Handshake one AR in the current cycle and leave the bench one cycle later.
  task automatic issue_ar(input logic [7:0] len, input string name);
    arvalid = 1'b1;
    arlen   = len;
    #1;
    chk1(name, arready, 1'b1);
    chk1({name, "_w"}, arready_w, 1'b1);
    cyc();
    arvalid = 1'b0;
  endtask

  // i = 1 is the current cycle; returns the first cycle each instance shows rvalid.
  task automatic wait_rv(input int budget, output int lat_m, output int lat_w);
    lat_m = 0;
    lat_w = 0;
    for (int i = 1; i <= budget; i++) begin
      if (rvalid && lat_m == 0) lat_m = i;
      if (rvalid_w && lat_w == 0) lat_w = i;
      if (lat_m != 0 && lat_w != 0) break;
      cyc();
    end
  endtask

  task automatic count_beats(input int budget, output int n);
    n = 0;
    while (rvalid && n < budget) begin
      n++;
      cyc();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int lm, lw, nb, bad_rdy, bad_rv, hi;

    // aw w wl br st | awready wready bvalid
    wt[0]  = mk(8'b0110_0100);
    wt[1]  = mk(8'b1110_0100);
    wt[2]  = mk(8'b0110_0110);
    wt[3]  = mk(8'b0000_0100);
    wt[4]  = mk(8'b0000_0100);
    wt[5]  = mk(8'b0000_0101);
    wt[6]  = mk(8'b0001_1001);
    wt[7]  = mk(8'b0001_0101);
    wt[8]  = mk(8'b1000_0100);
    wt[9]  = mk(8'b1110_0110);
    wt[10] = mk(8'b0100_0110);
    wt[11] = mk(8'b0110_0110);
    wt[12] = mk(8'b0110_0101);
    wt[13] = mk(8'b0001_0101);
    wt[14] = mk(8'b0001_0101);
    wt[15] = mk(8'b0001_0100);

    resetn = 1'b1;
    idle_in();
    #2;
    resetn = 1'b0;
    #1;
    chk1("rst_arready", arready, 1'b0);
    chk1("rst_awready", awready, 1'b0);
    chk1("rst_wready", wready, 1'b0);
    chk1("rst_rvalid", rvalid, 1'b0);
    chk1("rst_bvalid", bvalid, 1'b0);
    chk1("rst_rvalid_w", rvalid_w, 1'b0);
    cyc();
    cyc();
    resetn = 1'b1;

    // Single read of 4 beats.
    do_reset();
    rready = 1'b1;
    issue_ar(8'd3, "rd1_arready");
    wait_rv(80, lm, lw);
    chkn("rd1_latency", lm, 25);
    chkn("rd1_latency_w", lw, 25);
    count_beats(300, nb);
    chkn("rd1_beats", nb, 4);
    chk1("rd1_rvalid_low", rvalid, 1'b0);

    // Read queue full: 8 accepted, 9th waits for the first pop.
    do_reset();
    arlen   = 8'd0;
    arvalid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk1($sformatf("qfull_accept%0d", i), arready, 1'b1);
      cyc();
    end
    #1;
    chk1("qfull_block", arready, 1'b0);
    wait_rv(80, lm, lw);
    chkn("qfull_first_latency", 7 + lm, 25);
    rready = 1'b1;
    #1;
    chk1("qfull_still_full", arready, 1'b0);
    cyc();
    rready = 1'b0;
    #1;
    chk1("qfull_9th_accept", arready, 1'b1);
    chk1("qfull_no_bubble", rvalid, 1'b1);
    cyc();
    arvalid = 1'b0;
    rready  = 1'b1;
    #1;
    chk1("qfull_refull", arready, 1'b0);
    count_beats(50, nb);
    chkn("qfull_b2b_beats", nb, 7);

    // Write path vectors.
    do_reset();
    for (int i = 0; i < 16; i++) begin
      awvalid = wt[i].aw;
      wvalid  = wt[i].w;
      wlast   = wt[i].wl;
      bready  = wt[i].br;
      stall   = wt[i].st;
      #1;
      chk1($sformatf("wr%0d_awready", i), awready, wt[i].e_awr);
      chk1($sformatf("wr%0d_wready", i), wready, wt[i].e_wr);
      chk1($sformatf("wr%0d_bvalid", i), bvalid, wt[i].e_bv);
      cyc();
    end
    idle_in();

    // Unmatched-AW limit.
    do_reset();
    awvalid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk1($sformatf("aw_limit_accept%0d", i), awready, 1'b1);
      cyc();
    end
    #1;
    chk1("aw_limit_block", awready, 1'b0);
    chk1("aw_limit_wready", wready, 1'b1);
    awvalid = 1'b0;

    // Stall during read delay, then stall mid-burst.
    do_reset();
    issue_ar(8'd1, "stl_arready");
    repeat (10) cyc();
    bad_rdy = 0;
    bad_rv  = 0;
    awvalid = 1'b1;
    arvalid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      stall = 1'b1;
      #1;
      if (arready || awready || wready) bad_rdy++;
      if (rvalid) bad_rv++;
      cyc();
    end
    chkn("stl_readies_low", bad_rdy, 0);
    chkn("stl_rvalid_held_low", bad_rv, 0);
    stall   = 1'b0;
    awvalid = 1'b0;
    arvalid = 1'b0;
    wait_rv(80, lm, lw);
    chkn("stl_latency", 30 + lm, 45);
    rready = 1'b1;
    bad_rv = 0;
    for (int i = 0; i < 5; i++) begin
      stall = 1'b1;
      #1;
      if (!rvalid) bad_rv++;
      cyc();
    end
    chkn("stl_burst_rvalid_held", bad_rv, 0);
    stall = 1'b0;
    count_beats(50, nb);
    chkn("stl_burst_beats", nb, 2);

    // Model-time wrap on the 6-bit instance: AR at now = 60, due wraps to 21.
    do_reset();
    rready = 1'b1;
    for (int i = 0; i < 200 && (now_m % 64) != 60; i++) cyc();
    issue_ar(8'd0, "wrap_arready");
    wait_rv(80, lm, lw);
    chkn("wrap_latency_w", lw, 25);
    chkn("wrap_latency", lm, 25);

    // Reset asserted during beat 2 of 8.
    do_reset();
    rready = 1'b1;
    issue_ar(8'd7, "rstb_arready");
    wait_rv(80, lm, lw);
    chkn("rstb_latency", lm, 25);
    cyc();
    cyc();
    #1;
    chk1("rstb_beat2_valid", rvalid, 1'b1);
    resetn = 1'b0;
    now_m  = 0;
    #1;
    chk1("rstb_rvalid_cleared", rvalid, 1'b0);
    chk1("rstb_rvalid_w_cleared", rvalid_w, 1'b0);
    cyc();
    cyc();
    resetn = 1'b1;
    hi = 0;
    for (int i = 0; i < 60; i++) begin
      if (rvalid || rvalid_w) hi++;
      cyc();
    end
    chkn("rstb_no_stale_beats", hi, 0);
    issue_ar(8'd0, "rstb_new_arready");
    wait_rv(80, lm, lw);
    chkn("rstb_new_latency", lm, 25);
    count_beats(50, nb);
    chkn("rstb_new_beats", nb, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
